// File: rtl/seq_mul5_ctrl.sv
// seq_mul5_ctrl: 5x5 unsigned shift-and-add multiplier sequenced over one shared 5-bit ripple-carry adder.
module lab4_2 (
   input  logic [4:0] in_a,
   input  logic [4:0] in_b,
   input  logic       in_c,
   output logic [4:0] out_s,
   output logic       out_c
);
   logic [5:0] c;
   assign c[0] = in_c;
   for (genvar g = 0; g < 5; g++) begin : g_fa
      assign out_s[g]  = in_a[g] ^ in_b[g] ^ c[g];
      assign c[g + 1]  = (in_a[g] & in_b[g]) | (c[g] & (in_a[g] ^ in_b[g]));
   end
   assign out_c = c[5];
endmodule

module seq_mul5_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_start,
   input  logic [4:0] in_a,
   input  logic [4:0] in_b,
   output logic [9:0] out_p,
   output logic       out_busy,
   output logic       out_done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t     state_q;
   logic [4:0] m_q, a_q, q_q, s, a_d, q_d;
   logic [2:0] cnt_q;
   logic [9:0] p_q;
   logic       co;
   lab4_2 u_add (
      .in_a (a_q),
      .in_b (q_q[0] ? m_q : 5'b0),
      .in_c (1'b0),
      .out_s(s),
      .out_c(co)
   );
   // The adder carry shifts straight into A[4], so no separate carry register is needed.
   assign a_d = {co, s[4:1]};
   assign q_d = {s[0], q_q[4:1]};
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         m_q     <= '0;
         a_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_start) begin
               m_q     <= in_a;
               q_q     <= in_b;
               a_q     <= '0;
               cnt_q   <= '0;
               state_q <= RUN;
            end
            RUN: begin
               a_q   <= a_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd4) begin
                  p_q     <= {a_d, q_d};
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign out_p    = p_q;
   assign out_busy = state_q != IDLE;
   assign out_done = state_q == DONE;
endmodule
